// File: rtl/frac_clock_divider.sv
// frac_clock_divider: fractional-N clock divider.
// Nout half-period is N Clock cycles, with N an unsigned fixed-point value
// (FRAC_BITS fraction bits). Fractional N alternates floor/ceil intervals so
// the average half-period is exactly N. A new N can be offered at any time
// through a valid/ready handshake and takes effect only at a toggle boundary.
// Optional build macro FRACDIV_COUNT_EN adds the `periods` rise counter.
module frac_clock_divider #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] N_in,
    output logic             cfg_err,
    output logic             Nout,
    output logic             rise,
    output logic             fall,
    output logic             running,
    output logic [WIDTH-1:0] n_active
`ifdef FRACDIV_COUNT_EN
    ,
    output logic [WIDTH-1:0] periods
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] pending_reg;
    logic             pending_valid_reg;

    logic             accept;
    logic             legal;
    logic             take;
    logic             hit;
    logic [WIDTH-1:0] eff_n;
    logic             start;
    logic             stop_low;
    logic             toggle;

    // Handshake, legality and toggle decisions for the coming edge.
    always_comb begin
        accept   = load_valid & ~pending_valid_reg;
        legal    = (N_in >= ONE);
        take     = accept & legal;
        // Only integer parts are compared; fraction bits of target carry
        // into later half-periods, which yields the floor/ceil pattern.
        hit      = (acc_reg[WIDTH-1:FRAC_BITS] == target_reg[WIDTH-1:FRAC_BITS]);
        // A queued N is always the one to use next.
        eff_n    = pending_valid_reg ? pending_reg : n_active;
        start    = (state_reg == IDLE) & en & (eff_n != '0);
        // Stopping while low wins over a due rising toggle: no runt pulse.
        stop_low = (state_reg == RUN) & ~en & ~Nout;
        toggle   = (state_reg == RUN) & hit & ~stop_low;
    end

    assign load_ready = ~pending_valid_reg;
    assign running    = (state_reg == RUN);

    // Main sequencer: state, accumulators, reload queue and output pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg         <= IDLE;
            acc_reg           <= '0;
            target_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            n_active          <= '0;
            Nout              <= 1'b0;
            rise              <= 1'b0;
            fall              <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            rise    <= 1'b0;
            fall    <= 1'b0;
            cfg_err <= accept & ~legal;
            case (state_reg)
                IDLE: begin
                    // Drain any queued N so IDLE never holds a pending value.
                    n_active          <= eff_n;
                    pending_valid_reg <= 1'b0;
                    if (start) begin
                        state_reg  <= RUN;
                        acc_reg    <= ONE;
                        target_reg <= eff_n;
                        // A load on the start edge belongs to the run.
                        if (take) begin
                            pending_reg       <= N_in;
                            pending_valid_reg <= 1'b1;
                        end
                    end else if (take) begin
                        n_active <= N_in;
                    end
                end
                RUN: begin
                    acc_reg <= acc_reg + ONE;
                    if (stop_low) begin
                        state_reg         <= IDLE;
                        n_active          <= eff_n;
                        pending_valid_reg <= 1'b0;
                    end else if (toggle) begin
                        Nout              <= ~Nout;
                        rise              <= ~Nout;
                        fall              <= Nout;
                        target_reg        <= target_reg + eff_n;
                        n_active          <= eff_n;
                        pending_valid_reg <= 1'b0;
                        // Falling edge completes a requested stop.
                        if (Nout && !en) begin
                            state_reg <= IDLE;
                        end
                    end
                    // Later assignment: a new N queues behind the toggle.
                    if (take) begin
                        pending_reg       <= N_in;
                        pending_valid_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FRACDIV_COUNT_EN
    // Count rising edges of Nout; only Reset clears it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            periods <= '0;
        end else if (toggle && !Nout) begin
            periods <= periods + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_frac_clock_divider.sv
// Testbench for frac_clock_divider: table vectors, hand sequences for reload,
// stop, fractional N and 8-bit wrap, then random stimulus against a model
// that schedules toggles from the running sum of half-periods.
module tb_frac_clock_divider;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        en = 1'b0;
    logic        lv = 1'b0;
    logic [31:0] nin = '0;
    logic        load_ready, cfg_err, Nout, rise, fall, running;
    logic [31:0] n_active;
`ifdef FRACDIV_COUNT_EN
    logic [31:0] periods;
    logic [7:0]  periods8;
`endif

    logic        rst8 = 1'b0;
    logic        en8 = 1'b0;
    logic        lv8 = 1'b0;
    logic [7:0]  nin8 = '0;
    logic        rdy8, cfg8, nout8, rise8, fall8, run8;
    logic [7:0]  nact8;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    frac_clock_divider #(.WIDTH(32), .FRAC_BITS(3)) dut (
        .Clock(Clock), .Reset(Reset), .en(en), .load_valid(lv),
        .load_ready(load_ready), .N_in(nin), .cfg_err(cfg_err), .Nout(Nout),
        .rise(rise), .fall(fall), .running(running), .n_active(n_active)
`ifdef FRACDIV_COUNT_EN
        , .periods(periods)
`endif
    );

    frac_clock_divider #(.WIDTH(8), .FRAC_BITS(3)) dut8 (
        .Clock(Clock), .Reset(rst8), .en(en8), .load_valid(lv8),
        .load_ready(rdy8), .N_in(nin8), .cfg_err(cfg8), .Nout(nout8),
        .rise(rise8), .fall(fall8), .running(run8), .n_active(nact8)
`ifdef FRACDIV_COUNT_EN
        , .periods(periods8)
`endif
    );

    // Reference model state (32-bit instance, 3 fraction bits).
    bit          m_run, m_nout, m_rise, m_fall, m_cfg, m_pv;
    logic [31:0] m_nact, m_pend, m_periods;
    longint      m_edge;   // edges since entering RUN
    longint      m_next;   // unbounded fixed-point time of next toggle

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_nout = 0; m_rise = 0; m_fall = 0; m_cfg = 0; m_pv = 0;
        m_nact = '0; m_pend = '0; m_periods = '0; m_edge = 0; m_next = 0;
    endtask

    // The k-th toggle falls on edge floor(sum of first k half-periods).
    task automatic model_step();
        bit          accept, legal;
        logic [31:0] nxt;
        accept = lv && !m_pv;
        legal  = (nin >= 32'd8);
        m_rise = 0; m_fall = 0;
        m_cfg  = accept && !legal;
        if (!m_run) begin
            nxt = m_pv ? m_pend : m_nact;
            m_nact = nxt; m_pv = 0;
            if (en && nxt != 0) begin
                m_run = 1; m_edge = 0; m_next = longint'(nxt);
                if (accept && legal) begin m_pend = nin; m_pv = 1; end
            end else if (accept && legal) begin
                m_nact = nin;
            end
        end else begin
            m_edge++;
            if (!en && !m_nout) begin
                m_run = 0;
                if (m_pv) m_nact = m_pend;
                m_pv = 0;
            end else if (m_edge == (m_next / 8)) begin
                nxt = m_pv ? m_pend : m_nact;
                m_next = m_next + longint'(nxt);
                m_nact = nxt; m_pv = 0;
                if (m_nout) begin
                    m_nout = 0; m_fall = 1;
                    if (!en) m_run = 0;
                end else begin
                    m_nout = 1; m_rise = 1; m_periods = m_periods + 1;
                end
            end
            if (accept && legal) begin m_pend = nin; m_pv = 1; end
        end
    endtask

    task automatic cmp_all(string tag);
        check({tag, ".Nout"}, 64'(Nout), 64'(m_nout));
        check({tag, ".rise"}, 64'(rise), 64'(m_rise));
        check({tag, ".fall"}, 64'(fall), 64'(m_fall));
        check({tag, ".running"}, 64'(running), 64'(m_run));
        check({tag, ".n_active"}, 64'(n_active), 64'(m_nact));
        check({tag, ".load_ready"}, 64'(load_ready), 64'(!m_pv));
        check({tag, ".cfg_err"}, 64'(cfg_err), 64'(m_cfg));
`ifdef FRACDIV_COUNT_EN
        check({tag, ".periods"}, 64'(periods), 64'(m_periods));
`endif
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge Clock);
        #1;
        cmp_all(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b0; lv = 1'b0; en = 1'b0; nin = '0;
        #2;
        model_reset();
        cmp_all("reset");
        Reset = 1'b1;
    endtask

    // Advance until a rise/fall pulse; n is the number of edges taken.
    task automatic wait_toggle(string tag, output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(tag);
            if (rise || fall) begin
                n = i;
                return;
            end
        end
        errors++;
        checks++;
        $display("FAIL %s: no toggle within 200 cycles", tag);
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] nin;
        logic        en;
        logic        nout, rise, fall, run, rdy, cfg;
        logic [31:0] nact;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, cnt, last, bad;
        int iv[4];
        int exp_iv[4];

        // Vectors start right after reset release: N=2.0 run, illegal load,
        // reload to 5.0, then stop while high (stop completes on the fall).
        tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
        tbl[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[2]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[6]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[8]  = '{1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h28};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h28};

        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        rst8 = 1'b1;
        do_reset();
        check("reset.n_active_zero", 64'(n_active), 64'h0);
        check("reset.load_ready_one", 64'(load_ready), 64'h1);

        // Table-driven vectors.
        for (int i = 0; i < 11; i++) begin
            lv = tbl[i].lv; nin = tbl[i].nin; en = tbl[i].en;
            tick("vec");
            $display("vec %0d: lv=%0b N_in=%0h en=%0b -> Nout=%0b rise=%0b fall=%0b run=%0b rdy=%0b cfg=%0b n_active=%0h",
                     i, tbl[i].lv, tbl[i].nin, tbl[i].en, Nout, rise, fall, running, load_ready, cfg_err, n_active);
            check("tbl.Nout", 64'(Nout), 64'(tbl[i].nout));
            check("tbl.rise", 64'(rise), 64'(tbl[i].rise));
            check("tbl.fall", 64'(fall), 64'(tbl[i].fall));
            check("tbl.running", 64'(running), 64'(tbl[i].run));
            check("tbl.load_ready", 64'(load_ready), 64'(tbl[i].rdy));
            check("tbl.cfg_err", 64'(cfg_err), 64'(tbl[i].cfg));
            check("tbl.n_active", 64'(n_active), 64'(tbl[i].nact));
        end
        lv = 1'b0;

        // N = 2.5: intervals 2,3,2,3 and 16 toggles in 40 cycles.
        do_reset();
        lv = 1'b1; nin = 32'h14; tick("frac.load");
        lv = 1'b0; en = 1'b1; tick("frac.start");
        cnt = 0; last = 0;
        for (int e = 1; e <= 40; e++) begin
            tick("frac");
            if (rise || fall) begin
                if (cnt < 4) iv[cnt] = e - last;
                last = e;
                cnt++;
            end
        end
        exp_iv[0] = 2; exp_iv[1] = 3; exp_iv[2] = 2; exp_iv[3] = 3;
        check("frac.toggles40", 64'(cnt), 64'd16);
        for (int k = 0; k < 4; k++) check("frac.interval", 64'(iv[k]), 64'(exp_iv[k]));
        $display("seq frac 2.5: toggles=%0d intervals=%0d,%0d,%0d,%0d", cnt, iv[0], iv[1], iv[2], iv[3]);
        en = 1'b0;
        repeat (6) tick("frac.stop");
        check("frac.stopped", 64'(running), 64'h0);

        // Reload 3.0 -> 5.0 in the middle of a half-period.
        do_reset();
        lv = 1'b1; nin = 32'h18; tick("reload.load");
        lv = 1'b0; en = 1'b1; tick("reload.start");
        wait_toggle("reload.t1", n);
        check("reload.first", 64'(n), 64'd3);
        tick("reload.mid");
        lv = 1'b1; nin = 32'h28; tick("reload.offer");
        lv = 1'b0;
        check("reload.ready_low", 64'(load_ready), 64'h0);
        wait_toggle("reload.t2", n);
        check("reload.old_half", 64'(n), 64'd1);
        check("reload.ready_back", 64'(load_ready), 64'h1);
        check("reload.n_active", 64'(n_active), 64'h28);
        wait_toggle("reload.t3", n);
        check("reload.new_half_a", 64'(n), 64'd5);
        wait_toggle("reload.t4", n);
        check("reload.new_half_b", 64'(n), 64'd5);
        en = 1'b0;
        tick("reload.stop");
        check("reload.idle", 64'(running), 64'h0);
        $display("seq reload 3.0->5.0: done, n_active=%0h", n_active);

        // Stop requested while high at N = 4.0.
        do_reset();
        lv = 1'b1; nin = 32'h20; tick("stop.load");
        lv = 1'b0; en = 1'b1; tick("stop.start");
        wait_toggle("stop.rise", n);
        check("stop.rise_at", 64'(n), 64'd4);
        check("stop.high", 64'(Nout), 64'h1);
        en = 1'b0;
        wait_toggle("stop.fall", n);
        check("stop.fall_at", 64'(n), 64'd4);
        check("stop.fall_pulse", 64'(fall), 64'h1);
        check("stop.not_running", 64'(running), 64'h0);
        check("stop.nout_low", 64'(Nout), 64'h0);
`ifdef FRACDIV_COUNT_EN
        check("stop.periods", 64'(periods), 64'd1);
`endif
        repeat (3) tick("stop.hold");
        $display("seq stop-while-high: Nout=%0b running=%0b", Nout, running);

        // 8-bit instance, N = 7.0: accumulators wrap many times in 200 cycles.
        lv8 = 1'b1; nin8 = 8'h38; tick("w8.load");
        lv8 = 1'b0; en8 = 1'b1; tick("w8.start");
        check("w8.n_active", 64'(nact8), 64'h38);
        check("w8.cfg_err", 64'(cfg8), 64'h0);
        check("w8.ready", 64'(rdy8), 64'h1);
        cnt = 0; last = 0; bad = 0;
        for (int e = 1; e <= 200; e++) begin
            tick("w8");
            if (rise8 || fall8) begin
                if (e - last != 7) bad++;
                last = e;
                cnt++;
            end
        end
        check("w8.toggles200", 64'(cnt), 64'd28);
        check("w8.bad_intervals", 64'(bad), 64'd0);
        $display("seq wrap8 N=7.0: toggles=%0d bad_intervals=%0d", cnt, bad);
        n = 0;
        for (int i = 0; i < 20 && !nout8; i++) begin
            tick("w8.seek");
            n++;
        end
        check("w8.high_found", 64'(nout8), 64'h1);
        rst8 = 1'b0;
        #1;
        check("w8.reset_nout", 64'(nout8), 64'h0);
        check("w8.reset_running", 64'(run8), 64'h0);
        check("w8.reset_rise", 64'(rise8), 64'h0);
        en8 = 1'b0;
        #1;
        rst8 = 1'b1;

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 4) en = ~en;
            lv = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) nin = 32'($urandom_range(0, 7));
            else nin = 32'($urandom_range(8, 96));
            if (lv && load_ready)
                $display("rand load: N_in=%0h legal=%0b running=%0b", nin, nin >= 32'd8, running);
            tick("rand");
        end
        lv = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frac_clock_divider.md
Name: frac_clock_divider

Overview:
- Parametrised fractional-N clock divider; successor to the single-channel fixed-point half-period generator.
- Produces `Nout`, whose half-period is a fixed-point count N of `Clock` cycles (integer or fractional, average-exact).
- Adds enable/stop control, a glitch-free valid/ready reload of N, rejection of illegal N, and edge pulses.
- Sits between the system clock and peripherals that need derived strobes or clocks.

Parameters:
- WIDTH, 32: width of N and of the internal time/target accumulators.
- FRAC_BITS, 3: number of fraction bits in N (binary point position); requires 1 <= FRAC_BITS < WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- en  input  1  run request; level-sensitive.
- load_valid  input  1  new N offered on N_in.
- load_ready  output  1  high when no reload is pending.
- N_in  input  WIDTH  half-period, unsigned fixed point, FRAC_BITS fraction bits.
- cfg_err  output  1  one-cycle pulse: a loaded N was illegal and discarded.
- Nout  output  1  divided clock.
- rise  output  1  one-cycle pulse on the edge where Nout goes 0->1.
- fall  output  1  one-cycle pulse on the edge where Nout goes 1->0.
- running  output  1  high in RUN state.
- n_active  output  WIDTH  half-period currently in use.

Behaviour:
- Reset (async, Reset=0) values:
  - Nout=0, rise=0, fall=0, cfg_err=0, running=0, n_active=0.
  - Internal: acc=0, target=0, pending_valid=0, pending=0.
  - load_ready=1; state IDLE.
- Constants and legality:
  - ONE = 1<<FRAC_BITS.
  - N is legal iff N >= ONE (integer part >= 1).
- Load handshake:
  - A transfer occurs when load_valid & load_ready.
  - load_ready = ~pending_valid.
  - Illegal N: discarded, cfg_err pulses on the next cycle, pending unchanged.
  - Legal N in IDLE: n_active <= N_in directly; pending stays empty.
  - Legal N in RUN: pending <= N_in, pending_valid <= 1.
- State IDLE:
  - Nout=0, acc and target frozen.
  - If en=1 and n_active != 0: go to RUN, acc <= ONE, target <= n_active.
  - If n_active == 0, en is ignored.
- State RUN, every cycle: acc <= acc + ONE (modulo 2^WIDTH).
- Toggle rule:
  - Toggle when acc[WIDTH-1:FRAC_BITS] == target[WIDTH-1:FRAC_BITS]; Nout <= ~Nout and the matching rise/fall pulses.
  - On toggle, step = pending_valid ? pending : n_active; target <= target + step.
  - If pending_valid: n_active <= pending and pending_valid <= 0 on the same edge. A reload never splits a half-period.
  - All arithmetic wraps modulo 2^WIDTH; the equality compare stays correct across wrap because step >= ONE.
- Timing:
  - With integer N=k, toggles occur every k cycles; the first toggle is k cycles after the IDLE->RUN edge.
  - Fractional N gives half-periods floor/ceil(N) averaging exactly N; e.g. N=2.5 gives intervals 2,3,2,3...
- Stop:
  - en=0 in RUN with Nout=0: go to IDLE on the next edge.
  - en=0 in RUN with Nout=1: stay in RUN until the next toggle (the falling edge), then go to IDLE on that same edge.
  - Output is never truncated to a runt high pulse.
- Simultaneous events:
  - A toggle and a handshake on the same edge: the toggle uses the old pending/n_active. The newly accepted N becomes pending.
  - IDLE entry with pending_valid=1: pending is copied to n_active and cleared.
- running = (state==RUN). rise and fall are never high together.
- Reset mid-operation: immediate return to reset values; no partial pulse is held.

Optional Feature:
- Macro FRACDIV_COUNT_EN.
- When defined:
  - Adds output `periods`, WIDTH bits, reset 0.
  - Increments on every rise pulse, wraps at 2^WIDTH.
  - Holds in IDLE, cleared only by Reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset low, then high with FRAC_BITS=3; load N_in=0x10 (2.0) in IDLE, en=1 -> running=1; Nout toggles every 2 cycles; first rise 2 cycles after the RUN entry edge; n_active=0x10.
- N_in=0x14 (2.5), en=1 -> toggle intervals alternate 2,3,2,3; over 40 cycles exactly 16 toggles.
- In RUN with N=3.0, load N_in=0x28 (5.0) mid half-period -> load_ready drops for one or more cycles; the current half-period completes at 3, subsequent half-periods are 5; load_ready returns to 1 on the toggle edge.
- Load N_in=0x04 (0.5) -> cfg_err pulses one cycle, n_active unchanged, load_ready stays 1.
- en=0 while Nout=1 at N=4.0 -> Nout stays high until its scheduled fall, fall pulse, then running=0 and Nout=0; with FRACDIV_COUNT_EN, periods equals the rise count.
- WIDTH=8, FRAC_BITS=3, N=7.0, run 200 cycles -> acc/target wrap with no missed or extra toggle; Reset asserted mid-high -> Nout=0 immediately.
